cmsdk_mcu_altfunc_seq: RTL and testbench
========================================

Name: cmsdk_mcu_altfunc_seq

Overview:
- Break-before-make sequencer for Port 1 alternate-function switching on the Cortex-M0 example MCU.
- Sits between the GPIO1 ALTFUNC/OUTEN outputs and the pin multiplexer, and drives the pin multiplexer's altfunc, outen and UART txen inputs.
- When a pin changes between GPIO and UART TX function, the block tristates that pin for a guard window, switches the function, holds the pin tristated for a settle window, then releases it.
- This prevents glitches and contention on the pad.

Parameters:
- GUARD_CYCLES, 4, tristate cycles before the function switch; legal range 1..255.
- SETTLE_CYCLES, 2, tristate cycles after the function switch; legal range 1..255.
- ALT_MASK, 16'h002A, P1 bits that have an alternate function (pins 1, 3, 5 = UART0/1/2 TXD). Bits outside the mask pass straight through.

Ports:
- PCLK  input  1  clock
- PRESET  input  1  synchronous active-high reset
- ctrl_en  input  1  1 = new switch sequences may start; 0 = no new sequence starts (a sequence already running completes)
- altfunc_req  input  16  requested altfunc (from GPIO1 ALTFUNC)
- outen_in  input  16  GPIO1 output enables
- uart_txen_in  input  3  UART0/1/2 txen
- altfunc_out  output  16  altfunc to pin mux
- outen_out  output  16  gated output enables to pin mux
- uart_txen_out  output  3  gated UART txen to pin mux
- busy  output  1  sequence in progress
- switch_done  output  1  one-cycle pulse when a sequence completes

Behaviour:
- One clock (PCLK); synchronous active-high reset (PRESET). All registers update on the PCLK rising edge only.
- Reset values:
  - state = IDLE, cnt = 0, chg_mask = 0.
  - altfunc_out[ALT_MASK bits] = 0.
  - busy = 0, switch_done = 0.
  - Combinational outputs therefore equal outen_in and uart_txen_in during reset.
- Pass-through: altfunc_out[i] = altfunc_req[i] combinationally for every i not in ALT_MASK.
- diff = (altfunc_req ^ altfunc_out) & ALT_MASK, evaluated combinationally.
- FSM states: IDLE, HIZ, SWITCH, SETTLE.
  - IDLE: if ctrl_en and diff != 0, then chg_mask <= diff, cnt <= GUARD_CYCLES-1, go to HIZ. Otherwise stay in IDLE.
  - HIZ: if cnt == 0, go to SWITCH; else cnt <= cnt-1.
  - SWITCH (exactly 1 cycle):
    - For each bit i in chg_mask: altfunc_out[i] <= altfunc_req[i], sampled on this edge.
    - cnt <= SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: if cnt == 0, go to IDLE with chg_mask <= 0 and switch_done <= 1; else cnt <= cnt-1.
- switch_done is high for exactly one cycle: the first IDLE cycle after SETTLE.
- hiz[i] = chg_mask[i] while state != IDLE, decoded from registered state.
  - outen_out = outen_in & ~hiz.
  - uart_txen_out[k] = uart_txen_in[k] & ~hiz[2k+1], for k = 0..2.
- busy = (state != IDLE).
- Timing (IDLE -> HIZ transition at edge E):
  - hiz is asserted from the cycle after E.
  - altfunc_out changes at edge E+GUARD+1.
  - hiz is released after GUARD+1+SETTLE cycles in total.
- Concurrent request changes:
  - altfunc_req bits that change during a sequence but are not in chg_mask are ignored until IDLE, then start a new sequence.
  - A bit in chg_mask that reverts to its old value before SWITCH is written with the same value. The pin still completes its hiz window.
  - Back-to-back: if diff != 0 in the first IDLE cycle after a sequence (switch_done cycle), a new sequence starts on that edge.
- ctrl_en deassertion mid-sequence does not abort the sequence.
- Reset mid-sequence:
  - Next cycle: state = IDLE, altfunc_out masked bits = 0, hiz released.
  - No switch_done pulse.
- cnt is 8 bits wide; GUARD_CYCLES and SETTLE_CYCLES values of 0 are illegal and not supported.

Test Plan:
- Reset, then altfunc_req = 0x0002, outen_in = 0xFFFF, uart_txen_in = 3'b001, defaults -> outen_out[1] = 0 and uart_txen_out[0] = 0 for 7 cycles (4+1+2). altfunc_out[1] rises 5 cycles after busy rises. switch_done pulses once; then outen_out = 0xFFFF.
- altfunc_req = 0x002A in a single cycle -> one sequence with chg_mask = 0x002A. Bits 1, 3, 5 switch on the same edge. outen_out = 0xFFD5 during hiz.
- During HIZ of a bit-1 sequence, set altfunc_req[3] = 1 -> bit 3 is not tristated in the first sequence. A second sequence starts in the switch_done cycle; bit 3 is switched at the end of it.
- altfunc_req[7] = 1 -> altfunc_out[7] = 1 in the same cycle, busy stays 0, outen_out unchanged.
- ctrl_en = 0 with altfunc_req = 0x0020 -> no sequence, busy = 0. Set ctrl_en = 1 -> sequence starts on the next edge.
- PRESET asserted in SETTLE of a 0x0008 switch -> next cycle: busy = 0, altfunc_out = 0, outen_out = outen_in, switch_done = 0.

Source files
------------

// File: rtl/cmsdk_mcu_altfunc_seq.sv
// -----------------------------------------------------------------------------
// cmsdk_mcu_altfunc_seq
//
// Break-before-make sequencer for Port 1 alternate-function switching.
// This block sits between the GPIO1 ALTFUNC/OUTEN outputs and the pin
// multiplexer.
//
// When a pin that has an alternate function changes between GPIO and
// UART TX, the sequence runs in this order:
//   1. The pin is tristated for GUARD_CYCLES+1 cycles (HIZ, then SWITCH).
//   2. Its function select is updated.
//   3. The pin stays tristated for SETTLE_CYCLES more cycles.
//   4. The pin is released.
// The sequence keeps the pad free of glitches and contention.
//
// Ports:
//   PCLK, PRESET     clock and synchronous active-high reset
//   ctrl_en          allows new switch sequences to start
//   altfunc_req      requested ALTFUNC from GPIO1
//   outen_in         GPIO1 output enables
//   uart_txen_in     UART0/1/2 txen (these drive P1 pins 1/3/5)
//   altfunc_out      ALTFUNC to the pin mux. Masked bits are sequenced;
//                    all other bits pass through.
//   outen_out        output enables with the tristated pins forced low
//   uart_txen_out    UART txen with the tristated pins forced low
//   busy             a sequence is in progress
//   switch_done      one-cycle pulse in the first IDLE cycle after a sequence
// -----------------------------------------------------------------------------
module cmsdk_mcu_altfunc_seq #(
  parameter int          GUARD_CYCLES  = 4,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] ALT_MASK      = 16'h002A
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        ctrl_en,
  input  logic [15:0] altfunc_req,
  input  logic [15:0] outen_in,
  input  logic [2:0]  uart_txen_in,
  output logic [15:0] altfunc_out,
  output logic [15:0] outen_out,
  output logic [2:0]  uart_txen_out,
  output logic        busy,
  output logic        switch_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIZ    = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] chg_mask_q, chg_mask_d;
  logic [15:0] alt_q, alt_d;
  logic        switch_done_q, switch_done_d;

  logic [15:0] diff;
  logic [15:0] hiz;

  // Output and tristate decode.
  // Masked bits come from the sequenced register; unmasked bits pass straight
  // through. hiz is decoded from registered state only.
  always_comb begin
    altfunc_out = (alt_q & ALT_MASK) | (altfunc_req & ~ALT_MASK);
    diff        = (altfunc_req ^ altfunc_out) & ALT_MASK;
    if (state_q != IDLE) begin
      hiz = chg_mask_q;
    end else begin
      hiz = 16'h0000;
    end
    outen_out        = outen_in & ~hiz;
    uart_txen_out[0] = uart_txen_in[0] & ~hiz[1];
    uart_txen_out[1] = uart_txen_in[1] & ~hiz[3];
    uart_txen_out[2] = uart_txen_in[2] & ~hiz[5];
    busy             = (state_q != IDLE);
    switch_done      = switch_done_q;
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    chg_mask_d    = chg_mask_q;
    alt_d         = alt_q;
    switch_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // The set of pins to switch is latched here. Request bits that change
        // later are picked up by the next sequence.
        if (ctrl_en && (diff != 16'h0000)) begin
          chg_mask_d = diff;
          cnt_d      = GUARD_LOAD;
          state_d    = HIZ;
        end else begin
          state_d = IDLE;
        end
      end
      HIZ: begin
        if (cnt_q == 8'd0) begin
          state_d = SWITCH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SWITCH: begin
        // A request that reverted during HIZ is written back unchanged.
        alt_d   = ((alt_q & ~chg_mask_q) | (altfunc_req & chg_mask_q)) & ALT_MASK;
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          chg_mask_d    = 16'h0000;
          switch_done_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = 8'd0;
        chg_mask_d = 16'h0000;
      end
    endcase
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      chg_mask_q    <= 16'h0000;
      alt_q         <= 16'h0000;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chg_mask_q    <= chg_mask_d;
      alt_q         <= alt_d;
      switch_done_q <= switch_done_d;
    end
  end

endmodule

// File: tb/tb_cmsdk_mcu_altfunc_seq.sv
// Directed testbench for cmsdk_mcu_altfunc_seq (default parameters).
module tb_cmsdk_mcu_altfunc_seq;

  logic        PCLK;
  logic        PRESET;
  logic        ctrl_en;
  logic [15:0] altfunc_req;
  logic [15:0] outen_in;
  logic [2:0]  uart_txen_in;
  logic [15:0] altfunc_out;
  logic [15:0] outen_out;
  logic [2:0]  uart_txen_out;
  logic        busy;
  logic        switch_done;

  int n_cmp = 0;
  int n_err = 0;

  cmsdk_mcu_altfunc_seq dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .ctrl_en       (ctrl_en),
    .altfunc_req   (altfunc_req),
    .outen_in      (outen_in),
    .uart_txen_in  (uart_txen_in),
    .altfunc_out   (altfunc_out),
    .outen_out     (outen_out),
    .uart_txen_out (uart_txen_out),
    .busy          (busy),
    .switch_done   (switch_done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    altfunc_req = 16'h0000;
    step();
    step();
    PRESET = 1'b0;
  endtask

  initial begin
    PRESET       = 1'b1;
    ctrl_en      = 1'b1;
    altfunc_req  = 16'h0000;
    outen_in     = 16'hFFFF;
    uart_txen_in = 3'b001;
    step();
    step();
    // Reset state
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, switch_done}, 32'd0);
    check_val("rst_alt", {16'd0, altfunc_out}, 32'h0000);
    check_val("rst_outen", {16'd0, outen_out}, 32'hFFFF);
    check_val("rst_txen", {29'd0, uart_txen_out}, 32'h1);

    // Test 1: a single bit-1 switch with the default 4/2 windows
    PRESET = 1'b0;
    altfunc_req = 16'h0002;
    #1;
    check_val("t1_pre_alt", {16'd0, altfunc_out}, 32'h0000);
    step();
    for (int i = 1; i <= 7; i++) begin
      check_val("t1_busy", {31'd0, busy}, 32'd1);
      check_val("t1_outen", {16'd0, outen_out}, 32'hFFFD);
      check_val("t1_txen", {29'd0, uart_txen_out}, 32'h0);
      check_val("t1_done_lo", {31'd0, switch_done}, 32'd0);
      check_val("t1_alt", {16'd0, altfunc_out}, (i >= 6) ? 32'h0002 : 32'h0000);
      step();
    end
    check_val("t1_done", {31'd0, switch_done}, 32'd1);
    check_val("t1_idle", {31'd0, busy}, 32'd0);
    check_val("t1_outen_rel", {16'd0, outen_out}, 32'hFFFF);
    check_val("t1_txen_rel", {29'd0, uart_txen_out}, 32'h1);
    step();
    check_val("t1_done_pulse", {31'd0, switch_done}, 32'd0);

    // Test 2: three pins switch together in one sequence
    do_reset();
    uart_txen_in = 3'b111;
    altfunc_req = 16'h002A;
    step();
    for (int i = 1; i <= 7; i++) begin
      check_val("t2_outen", {16'd0, outen_out}, 32'hFFD5);
      check_val("t2_txen", {29'd0, uart_txen_out}, 32'h0);
      check_val("t2_alt", {16'd0, altfunc_out}, (i >= 6) ? 32'h002A : 32'h0000);
      step();
    end
    check_val("t2_done", {31'd0, switch_done}, 32'd1);
    check_val("t2_outen_rel", {16'd0, outen_out}, 32'hFFFF);
    check_val("t2_txen_rel", {29'd0, uart_txen_out}, 32'h7);

    // Test 3: bit 3 is requested during a bit-1 sequence
    do_reset();
    altfunc_req = 16'h0002;
    step();
    step();
    altfunc_req = 16'h000A;
    #1;
    check_val("t3_outen_seq1", {16'd0, outen_out}, 32'hFFFD);
    check_val("t3_txen_seq1", {29'd0, uart_txen_out}, 32'h6);
    for (int i = 0; i < 5; i++) step();
    check_val("t3_alt_seq1", {16'd0, altfunc_out}, 32'h0002);
    step();
    check_val("t3_done1", {31'd0, switch_done}, 32'd1);
    check_val("t3_idle1", {31'd0, busy}, 32'd0);
    step();
    check_val("t3_busy2", {31'd0, busy}, 32'd1);
    check_val("t3_outen_seq2", {16'd0, outen_out}, 32'hFFF7);
    for (int i = 0; i < 4; i++) step();
    check_val("t3_alt_pre", {16'd0, altfunc_out}, 32'h0002);
    step();
    check_val("t3_alt_post", {16'd0, altfunc_out}, 32'h000A);
    step();
    step();
    check_val("t3_done2", {31'd0, switch_done}, 32'd1);

    // Test 4: a pin outside the mask passes straight through
    altfunc_req = 16'h008A;
    #1;
    check_val("t4_alt", {16'd0, altfunc_out}, 32'h008A);
    check_val("t4_busy", {31'd0, busy}, 32'd0);
    check_val("t4_outen", {16'd0, outen_out}, 32'hFFFF);
    step();
    check_val("t4_busy_next", {31'd0, busy}, 32'd0);

    // Test 5: ctrl_en holds off a new sequence
    do_reset();
    ctrl_en = 1'b0;
    altfunc_req = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t5_hold_busy", {31'd0, busy}, 32'd0);
      check_val("t5_hold_alt", {16'd0, altfunc_out}, 32'h0000);
    end
    ctrl_en = 1'b1;
    #1;
    check_val("t5_en_comb", {31'd0, busy}, 32'd0);
    step();
    check_val("t5_start", {31'd0, busy}, 32'd1);
    check_val("t5_outen", {16'd0, outen_out}, 32'hFFDF);
    check_val("t5_txen", {29'd0, uart_txen_out}, 32'h3);

    // Test 6: reset during SETTLE of a bit-3 switch
    do_reset();
    altfunc_req = 16'h0008;
    step();
    for (int i = 0; i < 5; i++) step();
    check_val("t6_settle_busy", {31'd0, busy}, 32'd1);
    check_val("t6_settle_alt", {16'd0, altfunc_out}, 32'h0008);
    PRESET = 1'b1;
    step();
    check_val("t6_busy", {31'd0, busy}, 32'd0);
    check_val("t6_alt", {16'd0, altfunc_out}, 32'h0000);
    check_val("t6_outen", {16'd0, outen_out}, 32'hFFFF);
    check_val("t6_done", {31'd0, switch_done}, 32'd0);
    step();
    check_val("t6_done2", {31'd0, switch_done}, 32'd0);
    PRESET = 1'b0;
    altfunc_req = 16'h0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
